// File: rtl/ps2_mouse_bus.sv
// ps2_mouse_bus: bus-mapped PS/2 mouse receiver assembling 3-byte packets, raising interrupt 1 per packet.
// Define MOUSE_INIT_EN to have the host send 0xF4 (enable reporting) and await 0xFA after reset.
module ps2_mouse_bus #(
  parameter logic [7:0] BASE_ADDR      = 8'hA0,
  parameter int         TIMEOUT_CYCLES = 20000,
  parameter int         INHIBIT_CYCLES = 12000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  inout  wire        CLK_MOUSE,
  inout  wire        DATA_MOUSE
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  if (TIMEOUT_CYCLES < 2 || INHIBIT_CYCLES < 2) begin : g_badParams
    $error("ps2_mouse_bus: TIMEOUT_CYCLES and INHIBIT_CYCLES must be at least 2");
  end

  logic w_fall;
  logic w_rxEnable;
  logic w_pktEnable;
  logic w_clkLow;
  logic w_dataLow;

  // Synchronizers start high so reset release never looks like a falling clock edge.
  logic r_clkMeta, r_clkD1, r_clkD2;
  logic r_dataMeta, r_dataD1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_clkMeta  <= 1'b1;
      r_clkD1    <= 1'b1;
      r_clkD2    <= 1'b1;
      r_dataMeta <= 1'b1;
      r_dataD1   <= 1'b1;
    end else begin
      r_clkMeta  <= CLK_MOUSE;
      r_clkD1    <= r_clkMeta;
      r_clkD2    <= r_clkD1;
      r_dataMeta <= DATA_MOUSE;
      r_dataD1   <= r_dataMeta;
    end
  end

  assign w_fall = r_clkD2 & ~r_clkD1;

  typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_CHECK} rxState_t;

  rxState_t        r_rxState;
  logic [3:0]      r_bitCnt;
  logic [9:0]      r_shift;
  logic [TO_W-1:0] r_toCnt;
  logic            r_rxDone;
  logic            r_rxOk;
  logic            r_rxAbort;
  logic [7:0]      r_rxByte;

  // r_shift ends up as {stop, parity, data[7:0]} after the ten post-start edges.
  always_ff @(posedge CLK) begin
    if (RESET || !w_rxEnable) begin
      r_rxState <= RX_IDLE;
      r_bitCnt  <= 4'd0;
      r_shift   <= 10'd0;
      r_toCnt   <= '0;
      r_rxDone  <= 1'b0;
      r_rxOk    <= 1'b0;
      r_rxAbort <= 1'b0;
      r_rxByte  <= 8'd0;
    end else begin
      r_rxDone  <= 1'b0;
      r_rxAbort <= 1'b0;
      case (r_rxState)
        RX_IDLE: begin
          if (w_fall && !r_dataD1) begin
            r_rxState <= RX_BITS;
            r_bitCnt  <= 4'd0;
            r_toCnt   <= '0;
          end
        end
        RX_BITS: begin
          if (w_fall) begin
            r_shift <= {r_dataD1, r_shift[9:1]};
            r_toCnt <= '0;
            if (r_bitCnt == 4'd9) begin
              r_rxState <= RX_CHECK;
            end else begin
              r_bitCnt <= r_bitCnt + 4'd1;
            end
          end else if (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_rxState <= RX_IDLE;
            r_rxAbort <= 1'b1;
          end else begin
            r_toCnt <= r_toCnt + TO_W'(1);
          end
        end
        RX_CHECK: begin
          r_rxDone  <= 1'b1;
          r_rxOk    <= (^r_shift[8:0]) & r_shift[9];
          r_rxByte  <= r_shift[7:0];
          r_rxState <= RX_IDLE;
        end
        default: r_rxState <= RX_IDLE;
      endcase
    end
  end

`ifdef MOUSE_INIT_EN
  localparam int INIT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int INIT_W   = $clog2(INIT_MAX + 1);
  // Enable-reporting command followed by its odd parity bit.
  localparam logic [8:0] TX_FRAME = {1'b0, 8'hF4};

  typedef enum logic [2:0] {IN_INHIBIT, IN_RTS, IN_TX, IN_ACK, IN_RESP, IN_DONE} initState_t;

  initState_t        r_initState;
  logic [INIT_W-1:0] r_initCnt;
  logic [3:0]        r_txCnt;
  logic              r_clkLow;
  logic              r_dataLow;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_initState <= IN_INHIBIT;
      r_initCnt   <= '0;
      r_txCnt     <= 4'd0;
      r_clkLow    <= 1'b1;
      r_dataLow   <= 1'b0;
    end else begin
      case (r_initState)
        IN_INHIBIT: begin
          r_clkLow  <= 1'b1;
          r_dataLow <= 1'b0;
          if (r_initCnt == INIT_W'(INHIBIT_CYCLES - 1)) begin
            r_initCnt   <= '0;
            r_dataLow   <= 1'b1;
            r_initState <= IN_RTS;
          end else begin
            r_initCnt <= r_initCnt + INIT_W'(1);
          end
        end
        IN_RTS: begin
          r_clkLow    <= 1'b0;
          r_txCnt     <= 4'd0;
          r_initState <= IN_TX;
        end
        IN_TX, IN_ACK, IN_RESP: begin
          // Any silence of TIMEOUT_CYCLES from the device restarts the whole handshake.
          if (r_initCnt == INIT_W'(TIMEOUT_CYCLES - 1)) begin
            r_initState <= IN_INHIBIT;
            r_initCnt   <= '0;
            r_clkLow    <= 1'b1;
            r_dataLow   <= 1'b0;
          end else begin
            r_initCnt <= w_fall ? '0 : r_initCnt + INIT_W'(1);
            if (r_initState == IN_TX && w_fall) begin
              if (r_txCnt == 4'd9) begin
                r_dataLow   <= 1'b0;
                r_initState <= IN_ACK;
              end else begin
                r_dataLow <= ~TX_FRAME[r_txCnt];
                r_txCnt   <= r_txCnt + 4'd1;
              end
            end
            if (r_initState == IN_ACK && w_fall) begin
              r_initState <= r_dataD1 ? IN_INHIBIT : IN_RESP;
              r_initCnt   <= '0;
              r_clkLow    <= r_dataD1;
            end
            if (r_initState == IN_RESP && r_rxDone) begin
              r_initCnt <= '0;
              if (r_rxOk && r_rxByte == 8'hFA) begin
                r_initState <= IN_DONE;
              end else begin
                r_initState <= IN_INHIBIT;
                r_clkLow    <= 1'b1;
              end
            end
          end
        end
        IN_DONE: begin
          r_clkLow  <= 1'b0;
          r_dataLow <= 1'b0;
        end
        default: r_initState <= IN_INHIBIT;
      endcase
    end
  end

  assign w_rxEnable  = (r_initState == IN_RESP) || (r_initState == IN_DONE);
  assign w_pktEnable = (r_initState == IN_DONE);
  assign w_clkLow    = r_clkLow;
  assign w_dataLow   = r_dataLow;
`else
  assign w_rxEnable  = 1'b1;
  assign w_pktEnable = 1'b1;
  assign w_clkLow    = 1'b0;
  assign w_dataLow   = 1'b0;
`endif

  assign CLK_MOUSE  = w_clkLow  ? 1'b0 : 1'bz;
  assign DATA_MOUSE = w_dataLow ? 1'b0 : 1'bz;

  logic [7:0] w_offset;
  logic       w_inRange;
  logic       w_flagWrite;
  logic       w_byteIn;
  logic       w_pktDone;

  assign w_offset    = BUS_ADDR - BASE_ADDR;
  assign w_inRange   = (w_offset[7:2] == 6'd0);
  assign w_flagWrite = BUS_WE && w_inRange && (w_offset[1:0] == 2'd3);

  logic [1:0] r_byteIdx;
  logic [7:0] r_shadow0, r_shadow1;
  logic [7:0] r_status, r_dx, r_dy;
  logic [3:0] r_pktCnt;
  logic       r_err, r_ovr, r_raise;

  assign w_byteIn  = r_rxDone && w_pktEnable;
  assign w_pktDone = w_byteIn && r_rxOk && (r_byteIdx == 2'd2);

  // Flag clears are written first so a same-cycle error or overrun wins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_byteIdx <= 2'd0;
      r_shadow0 <= 8'd0;
      r_shadow1 <= 8'd0;
      r_status  <= 8'd0;
      r_dx      <= 8'd0;
      r_dy      <= 8'd0;
      r_pktCnt  <= 4'd0;
      r_err     <= 1'b0;
      r_ovr     <= 1'b0;
      r_raise   <= 1'b0;
    end else begin
      if (w_flagWrite) begin
        r_err <= 1'b0;
        r_ovr <= 1'b0;
      end
      if (r_rxAbort) begin
        r_byteIdx <= 2'd0;
      end
      if (w_byteIn) begin
        if (!r_rxOk) begin
          r_err     <= 1'b1;
          r_byteIdx <= 2'd0;
        end else begin
          case (r_byteIdx)
            2'd0: begin
              if (r_rxByte[3]) begin
                r_shadow0 <= r_rxByte;
                r_byteIdx <= 2'd1;
              end
            end
            2'd1: begin
              r_shadow1 <= r_rxByte;
              r_byteIdx <= 2'd2;
            end
            default: begin
              r_status  <= r_shadow0;
              r_dx      <= r_shadow1;
              r_dy      <= r_rxByte;
              r_pktCnt  <= r_pktCnt + 4'd1;
              r_byteIdx <= 2'd0;
              if (r_raise) begin
                r_ovr <= 1'b1;
              end
            end
          endcase
        end
      end
      if (w_pktDone) begin
        r_raise <= 1'b1;
      end else if (BUS_INTERRUPT_ACK) begin
        r_raise <= 1'b0;
      end
    end
  end

  assign BUS_INTERRUPT_RAISE = r_raise;

  logic [7:0] r_busOut;
  logic       r_busOe;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_busOut <= 8'd0;
      r_busOe  <= 1'b0;
    end else begin
      r_busOe <= !BUS_WE && w_inRange;
      case (w_offset[1:0])
        2'd0:    r_busOut <= r_status;
        2'd1:    r_busOut <= r_dx;
        2'd2:    r_busOut <= r_dy;
        default: r_busOut <= {r_pktCnt, 2'b00, r_ovr, r_err};
      endcase
    end
  end

  assign BUS_DATA = r_busOe ? r_busOut : 8'hzz;

endmodule

// File: tb/tb_ps2_mouse_bus.sv
// tb_ps2_mouse_bus: drives PS/2 frames into ps2_mouse_bus and checks bus reads and the interrupt
// against a byte-level packet model kept in the bench.
module tb_ps2_mouse_bus;

  localparam logic [7:0] BASE    = 8'hA0;
  localparam int         TIMEOUT = 300;
  localparam int         HALF    = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] busAddr = 8'h00;
  logic       busWe = 1'b0;
  logic       ack = 1'b0;
  logic       mouseClk = 1'b1;
  logic       mouseData = 1'b1;
  logic       raise;
  wire  [7:0] busData;
  wire        clkMouse;
  wire        dataMouse;

  assign clkMouse  = mouseClk;
  assign dataMouse = mouseData;

  ps2_mouse_bus #(
    .BASE_ADDR(BASE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .INHIBIT_CYCLES(100)
  ) dut (
    .CLK(clock),
    .RESET(reset),
    .BUS_DATA(busData),
    .BUS_ADDR(busAddr),
    .BUS_WE(busWe),
    .BUS_INTERRUPT_RAISE(raise),
    .BUS_INTERRUPT_ACK(ack),
    .CLK_MOUSE(clkMouse),
    .DATA_MOUSE(dataMouse)
  );

  always #5 clock = ~clock;

  // Packet-level model: accepted bytes queue up until three form a packet.
  logic [7:0] mStatus = 8'h00, mDx = 8'h00, mDy = 8'h00;
  logic [3:0] mPktCnt = 4'h0;
  logic       mErr = 1'b0, mOvr = 1'b0, mRaise = 1'b0;
  logic [7:0] mPending[$];
  logic       checkEn = 1'b0;
  int         errors = 0;
  int         checks = 0;

  function automatic logic [7:0] mFlags();
    return {mPktCnt, 2'b00, mOvr, mErr};
  endfunction

  task automatic modelReset();
    mStatus = 8'h00; mDx = 8'h00; mDy = 8'h00; mPktCnt = 4'h0;
    mErr = 1'b0; mOvr = 1'b0; mRaise = 1'b0;
    mPending.delete();
  endtask

  task automatic modelByte(input logic [7:0] b, input logic ok);
    if (!ok) begin
      mErr = 1'b1;
      mPending.delete();
    end else if (mPending.size() != 0 || b[3]) begin
      mPending.push_back(b);
      if (mPending.size() == 3) begin
        if (mRaise) mOvr = 1'b1;
        mRaise  = 1'b1;
        mStatus = mPending[0];
        mDx     = mPending[1];
        mDy     = mPending[2];
        mPktCnt = mPktCnt + 4'h1;
        mPending.delete();
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: actual=%02h required=%02h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checkEn) checkOutput("RAISE", {7'b0, raise}, {7'b0, mRaise});
  end

  // Stop-bit edge reaches the registers five system clocks after the pin falls.
  task automatic sendByte(input logic [7:0] b, input logic badPar);
    logic [10:0] frame;
    frame = {1'b1, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clock) mouseData = frame[i];
      repeat (HALF) @(negedge clock);
      mouseClk = 1'b0;
      if (i == 10) begin
        repeat (5) @(posedge clock);
        #1 modelByte(b, !badPar);
        repeat (HALF - 5) @(negedge clock);
      end else begin
        repeat (HALF) @(negedge clock);
      end
      mouseClk = 1'b1;
    end
    @(negedge clock) mouseData = 1'b1;
    repeat (2 * HALF) @(negedge clock);
  endtask

  task automatic sendPartial(input int nEdges);
    for (int i = 0; i < nEdges; i++) begin
      @(negedge clock) mouseData = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clock);
      mouseClk = 1'b0;
      repeat (HALF) @(negedge clock);
      mouseClk = 1'b1;
    end
    @(negedge clock) mouseData = 1'b1;
  endtask

  task automatic readReg(input logic [1:0] off, output logic [7:0] val);
    @(negedge clock);
    busAddr = BASE + {6'd0, off};
    busWe   = 1'b0;
    @(negedge clock);
    val     = busData;
    busAddr = 8'h00;
  endtask

  task automatic writeReg(input logic [1:0] off);
    @(negedge clock);
    busAddr = BASE + {6'd0, off};
    busWe   = 1'b1;
    @(posedge clock);
    #1 if (off == 2'd3) begin
      mErr = 1'b0;
      mOvr = 1'b0;
    end
    @(negedge clock);
    busWe   = 1'b0;
    busAddr = 8'h00;
  endtask

  task automatic pulseAck();
    @(negedge clock) ack = 1'b1;
    @(posedge clock);
    #1 mRaise = 1'b0;
    @(negedge clock) ack = 1'b0;
  endtask

  task automatic checkRegs();
    logic [7:0] v;
    readReg(2'd0, v); checkOutput("STATUS", v, mStatus);
    readReg(2'd1, v); checkOutput("DX", v, mDx);
    readReg(2'd2, v); checkOutput("DY", v, mDy);
    readReg(2'd3, v); checkOutput("FLAGS", v, mFlags());
  endtask

  task automatic checkLit(input string name, input logic [1:0] off, input logic [7:0] lit);
    logic [7:0] v;
    readReg(off, v);
    checkOutput(name, v, lit);
  endtask

  task automatic doReset();
    @(negedge clock);
    checkEn = 1'b0;
    reset   = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    modelReset();
    checkEn = 1'b1;
  endtask

  task automatic applyStimulus();
    logic [7:0] b;
    logic       bad;
    int         kind;

    doReset();
    checkLit("rst STATUS", 2'd0, 8'h00);
    checkLit("rst DX",     2'd1, 8'h00);
    checkLit("rst DY",     2'd2, 8'h00);
    checkLit("rst FLAGS",  2'd3, 8'h00);

    sendByte(8'h08, 1'b0); sendByte(8'h05, 1'b0); sendByte(8'hFB, 1'b0);
    checkLit("pkt1 STATUS", 2'd0, 8'h08);
    checkLit("pkt1 DX",     2'd1, 8'h05);
    checkLit("pkt1 DY",     2'd2, 8'hFB);
    checkLit("pkt1 FLAGS",  2'd3, 8'h10);
    pulseAck();

    sendByte(8'h08, 1'b0); sendByte(8'h05, 1'b1); sendByte(8'h02, 1'b0);
    checkOutput("par noRaise", {7'b0, raise}, 8'h00);
    checkLit("par FLAGS", 2'd3, 8'h11);
    sendByte(8'h18, 1'b0); sendByte(8'h7F, 1'b0); sendByte(8'h80, 1'b0);
    checkRegs();
    pulseAck();
    writeReg(2'd3);
    checkLit("clr FLAGS", 2'd3, 8'h20);
    writeReg(2'd0);
    checkLit("wr0 STATUS", 2'd0, 8'h18);

    sendByte(8'h00, 1'b0);
    sendByte(8'h09, 1'b0); sendByte(8'h01, 1'b0); sendByte(8'h02, 1'b0);
    checkLit("resync STATUS", 2'd0, 8'h09);
    checkLit("resync FLAGS",  2'd3, 8'h30);
    pulseAck();

    sendByte(8'h08, 1'b0); sendByte(8'h11, 1'b0); sendByte(8'h22, 1'b0);
    sendByte(8'h28, 1'b0); sendByte(8'h33, 1'b0); sendByte(8'h44, 1'b0);
    checkLit("ovr DX",    2'd1, 8'h33);
    checkLit("ovr FLAGS", 2'd3, 8'h52);
    writeReg(2'd3);
    checkLit("ovr clr FLAGS", 2'd3, 8'h50);
    pulseAck();

    sendByte(8'h08, 1'b0);
    sendPartial(5);
    repeat (TIMEOUT + 50) @(negedge clock);
    mPending.delete();
    sendByte(8'h0A, 1'b0); sendByte(8'h10, 1'b0); sendByte(8'h20, 1'b0);
    checkLit("to STATUS", 2'd0, 8'h0A);
    checkLit("to DX",     2'd1, 8'h10);
    checkLit("to DY",     2'd2, 8'h20);
    checkLit("to FLAGS",  2'd3, 8'h60);
    pulseAck();

    for (int n = 0; n < 12; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) sendByte(8'($urandom) & 8'hF7, 1'b0);
      for (int k = 0; k < 3; k++) begin
        b = 8'($urandom);
        if (k == 0 && $urandom_range(0, 5) != 0) b[3] = 1'b1;
        bad = ($urandom_range(0, 9) == 0);
        sendByte(b, bad);
      end
      if ($urandom_range(0, 2) != 0) checkRegs();
      if ($urandom_range(0, 3) == 0) writeReg(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) pulseAck();
    end
    checkRegs();

    sendByte(8'h0C, 1'b0);
    sendPartial(6);
    doReset();
    checkLit("midrst FLAGS", 2'd3, 8'h00);
    sendByte(8'h08, 1'b0); sendByte(8'h21, 1'b0); sendByte(8'h42, 1'b0);
    checkLit("midrst STATUS", 2'd0, 8'h08);
    checkLit("midrst DX",     2'd1, 8'h21);
    checkLit("midrst DY",     2'd2, 8'h42);
    checkLit("midrst FLAGS2", 2'd3, 8'h10);
    pulseAck();
    repeat (4) @(negedge clock);
  endtask

  initial begin
    applyStimulus();
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
